// File: rtl/fifo_port_reader.sv
// rtl/fifo_port_reader.sv - per-channel port-edge to FIFO read strobe with latency-aligned capture
// Optional per-channel underflow counter: define FIFO_PORT_READER_UFL_CNT_EN.
module fifo_port_reader #(
    parameter int CHANNELS    = 1,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
`ifdef FIFO_PORT_READER_UFL_CNT_EN
    ,
    parameter int UFL_CNT_W   = 8
`endif
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [CHANNELS-1:0]           i_req,
    input  logic [CHANNELS-1:0]           i_fifo_empty,
    input  logic [CHANNELS*DATA_W-1:0]    i_fifo_q,
    input  logic [CHANNELS-1:0]           i_clear_status,
    output logic [CHANNELS-1:0]           o_fifo_read_req,
    output logic [CHANNELS*DATA_W-1:0]    o_data,
    output logic [CHANNELS-1:0]           o_data_valid,
    output logic [CHANNELS-1:0]           o_busy,
    output logic [CHANNELS-1:0]           o_underflow,
    output logic [CHANNELS-1:0]           o_overrun
`ifdef FIFO_PORT_READER_UFL_CNT_EN
    ,
    output logic [CHANNELS*UFL_CNT_W-1:0] o_ufl_count
`endif
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [SYNC_STAGES-1:0] filled;
        logic                   sync_prev;
        logic                   armed;
        logic                   pend;
        logic                   strobe;
        logic                   valid;
        logic                   busy;
        logic                   ufl;
        logic                   ovr;
        logic [CNT_W-1:0]       cnt;
        logic [DATA_W-1:0]      data;
        state_t                 state;

        logic edge_det;
        logic capture;
        logic want;
        logic issue;
        logic ufl_set;
        logic ovr_set;
        logic pend_set;

        // A read can be launched from IDLE, or on the capture edge itself so that
        // back-to-back reads are spaced RD_LATENCY+1 clocks.
        always_comb begin
            edge_det = armed && sync[SYNC_STAGES-1] && !sync_prev;
            capture  = (state == WAIT) && (cnt == '0);
            want     = (state == IDLE) ? edge_det : (capture && (pend || edge_det));
            issue    = want && !i_fifo_empty[n];
            ufl_set  = want && i_fifo_empty[n];
            ovr_set  = pend && edge_det;
            pend_set = (state == WAIT) && !capture && edge_det && !pend;
        end

        always_ff @(posedge i_clock) begin
            if (!i_reset_n) begin
                sync      <= '0;
                filled    <= '0;
                sync_prev <= 1'b0;
                armed     <= 1'b0;
                pend      <= 1'b0;
                strobe    <= 1'b0;
                valid     <= 1'b0;
                busy      <= 1'b0;
                ufl       <= 1'b0;
                ovr       <= 1'b0;
                cnt       <= '0;
                data      <= '0;
                state     <= IDLE;
            end else begin
                sync      <= SYNC_STAGES'({sync, i_req[n]});
                filled    <= SYNC_STAGES'({filled, 1'b1});
                sync_prev <= sync[SYNC_STAGES-1];
                // Arm only on a genuinely sampled low, not on the reset-cleared chain.
                if (filled[SYNC_STAGES-1] && !sync[SYNC_STAGES-1]) begin
                    armed <= 1'b1;
                end
                strobe <= issue;
                if (capture) begin
                    data  <= i_fifo_q[n*DATA_W +: DATA_W];
                    valid <= 1'b1;
                end
                if (issue) begin
                    valid <= 1'b0;
                    busy  <= 1'b1;
                    cnt   <= CNT_W'(RD_LATENCY);
                    state <= WAIT;
                end else if (capture) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (state == WAIT) begin
                    cnt <= cnt - CNT_W'(1);
                end
                if (want) begin
                    pend <= 1'b0;
                end else if (pend_set) begin
                    pend <= 1'b1;
                end
                ufl <= ufl_set || (ufl && !i_clear_status[n]);
                ovr <= ovr_set || (ovr && !i_clear_status[n]);
            end
        end

        assign o_fifo_read_req[n]            = strobe;
        assign o_data[n*DATA_W +: DATA_W]    = data;
        assign o_data_valid[n]               = valid;
        assign o_busy[n]                     = busy;
        assign o_underflow[n]                = ufl;
        assign o_overrun[n]                  = ovr;

`ifdef FIFO_PORT_READER_UFL_CNT_EN
        logic [UFL_CNT_W-1:0] ucnt;

        always_ff @(posedge i_clock) begin
            if (!i_reset_n || i_clear_status[n]) begin
                ucnt <= '0;
            end else if (ufl_set && (ucnt != '1)) begin
                ucnt <= ucnt + UFL_CNT_W'(1);
            end
        end

        assign o_ufl_count[n*UFL_CNT_W +: UFL_CNT_W] = ucnt;
`endif
    end

endmodule

// File: tb/tb_fifo_port_reader.sv
// tb/tb_fifo_port_reader.sv - directed, table and randomized checks of fifo_port_reader
`timescale 1ns/1ps
module tb_fifo_port_reader;

    localparam int CH   = 4;
    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int LAT  = 3;
    localparam int UW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic [CH-1:0]      req;
    logic [CH-1:0]      empty;
    logic [CH*DW-1:0]   q;
    logic [CH-1:0]      clear;
    logic [CH-1:0]      strobe;
    logic [CH*DW-1:0]   data;
    logic [CH-1:0]      valid;
    logic [CH-1:0]      busy;
    logic [CH-1:0]      ufl;
    logic [CH-1:0]      ovr;
`ifdef FIFO_PORT_READER_UFL_CNT_EN
    logic [CH*UW-1:0]   ucount;
`endif

    fifo_port_reader #(
        .CHANNELS(CH), .DATA_W(DW), .SYNC_STAGES(SYNC), .RD_LATENCY(LAT)
`ifdef FIFO_PORT_READER_UFL_CNT_EN
        , .UFL_CNT_W(UW)
`endif
    ) dut (
        .i_clock(clk), .i_reset_n(reset_n), .i_req(req), .i_fifo_empty(empty),
        .i_fifo_q(q), .i_clear_status(clear), .o_fifo_read_req(strobe), .o_data(data),
        .o_data_valid(valid), .o_busy(busy), .o_underflow(ufl), .o_overrun(ovr)
`ifdef FIFO_PORT_READER_UFL_CNT_EN
        , .o_ufl_count(ucount)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe[CH];

    // Reference model: edges come from the sampled request history, reads are
    // tracked as transactions with an absolute capture cycle.
    logic [CH-1:0]    hist[$];
    bit               m_infl[CH];
    int               m_cap_at[CH];
    bit               m_pend[CH];
    int               m_ucnt[CH];
    logic [CH-1:0]    m_strobe, m_busy, m_valid, m_ufl, m_ovr;
    logic [CH*DW-1:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int c = 0; c < CH; c++) begin
            m_infl[c] = 0; m_cap_at[c] = 0; m_pend[c] = 0; m_ucnt[c] = 0;
        end
        m_strobe = '0; m_busy = '0; m_valid = '0; m_ufl = '0; m_ovr = '0; m_data = '0;
    endtask

    task automatic model_step();
        int k;
        if (!reset_n) begin
            model_reset();
            return;
        end
        hist.push_back(req);
        k = hist.size() - 1;
        m_strobe = '0;
        for (int c = 0; c < CH; c++) begin
            bit ev, cap, served, uset, oset;
            ev = (k >= SYNC + 1) && hist[k-SYNC][c] && !hist[k-SYNC-1][c];
            cap = m_infl[c] && (k == m_cap_at[c]);
            served = 0; uset = 0; oset = 0;
            if (cap) begin
                m_data[c*DW +: DW] = q[c*DW +: DW];
                m_valid[c] = 1'b1;
                m_infl[c] = 0;
            end
            if (!m_infl[c]) begin
                served = ev || (cap && m_pend[c]);
                oset = cap && m_pend[c] && ev;
            end else if (ev) begin
                if (m_pend[c]) oset = 1;
                else m_pend[c] = 1;
            end
            if (served) begin
                m_pend[c] = 0;
                if (empty[c]) uset = 1;
                else begin
                    m_strobe[c] = 1'b1;
                    m_valid[c] = 1'b0;
                    m_infl[c] = 1;
                    m_cap_at[c] = k + 1 + LAT;
                end
            end
            m_busy[c] = m_infl[c];
            m_ufl[c] = uset || (m_ufl[c] && !clear[c]);
            m_ovr[c] = oset || (m_ovr[c] && !clear[c]);
            if (clear[c]) m_ucnt[c] = 0;
            else if (uset && m_ucnt[c] < (1 << UW) - 1) m_ucnt[c]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("read_req", strobe, m_strobe);
        chk("busy", busy, m_busy);
        chk("data_valid", valid, m_valid);
        chk("data", data, m_data);
        chk("underflow", ufl, m_ufl);
        chk("overrun", ovr, m_ovr);
`ifdef FIFO_PORT_READER_UFL_CNT_EN
        for (int c = 0; c < CH; c++) chk("ufl_count", ucount[c*UW +: UW], m_ucnt[c]);
`endif
        for (int c = 0; c < CH; c++) if (strobe[c] === 1'b1) n_strobe[c]++;
    endtask

    typedef struct {
        logic       req;
        logic       empty;
        logic       clear;
        logic       exp_strobe;
        logic       exp_busy;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ufl;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_first, t_second;
        bit found;

        // Channel 0 read with q=A5, then an empty-FIFO request and a status clear.
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 8'h00, 0};
        tbl[2]  = '{1, 0, 0, 1, 1, 0, 8'h00, 0};
        tbl[3]  = '{1, 0, 0, 0, 1, 0, 8'h00, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 8'h00, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 8'h00, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 8'hA5, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 8'hA5, 0};
        tbl[8]  = '{1, 1, 0, 0, 0, 1, 8'hA5, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 1, 8'hA5, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 1, 8'hA5, 1};
        tbl[11] = '{1, 1, 0, 0, 0, 1, 8'hA5, 1};
        tbl[12] = '{0, 1, 0, 0, 0, 1, 8'hA5, 1};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 8'hA5, 1};
        tbl[14] = '{0, 1, 0, 0, 0, 1, 8'hA5, 1};
        tbl[15] = '{0, 1, 0, 0, 0, 1, 8'hA5, 1};
        tbl[16] = '{0, 0, 1, 0, 0, 1, 8'hA5, 0};

        reset_n = 0; req = '0; empty = '0; q = '0; clear = '0;
        for (int c = 0; c < CH; c++) n_strobe[c] = 0;
        model_reset();
        repeat (3) step();
        chk("reset_flags", {strobe, busy, valid, ufl, ovr}, '0);
        chk("reset_data", data, '0);
        reset_n = 1;
        repeat (4) step();

        q[7:0] = 8'hA5;
        for (int i = 0; i < 17; i++) begin
            req[0] = tbl[i].req; empty[0] = tbl[i].empty; clear[0] = tbl[i].clear;
            step();
            chk($sformatf("tbl%0d_strobe", i), strobe[0], tbl[i].exp_strobe);
            chk($sformatf("tbl%0d_busy", i), busy[0], tbl[i].exp_busy);
            chk($sformatf("tbl%0d_valid", i), valid[0], tbl[i].exp_valid);
            chk($sformatf("tbl%0d_data", i), data[7:0], tbl[i].exp_data);
            chk($sformatf("tbl%0d_underflow", i), ufl[0], tbl[i].exp_ufl);
        end
        clear = '0; empty = '0;
        repeat (3) step();

        // Back-to-back edges on ch2: pending serve on the capture edge, third edge dropped.
        n_strobe[2] = 0; t_first = -1; t_second = -1;
        for (int i = 0; i < 14; i++) begin
            req[2] = (i == 0 || i == 2 || i == 4);
            q[23:16] = 8'(8'h30 + i);
            step();
            if (strobe[2] === 1'b1) begin
                if (t_first < 0) t_first = i; else t_second = i;
            end
        end
        chk("t3_strobe_count", n_strobe[2], 2);
        chk("t3_spacing", t_second - t_first, LAT + 1);
        chk("t3_overrun", ovr[2], 1);
        chk("t3_last_data", data[23:16], 8'h3A);
        clear = 4'hF; step(); clear = '0;
        repeat (3) step();

        // Simultaneous edges on ch0 and ch3 with ch3 empty.
        empty[3] = 1'b1;
        req[0] = 1'b1; req[3] = 1'b1;
        step(); step(); step();
        chk("t6_strobe", strobe, 4'b0001);
        chk("t6_underflow", ufl, 4'b1000);
        step();
        req = '0; empty = '0;
        repeat (8) step();
        clear = 4'hF; step(); clear = '0;

        // Request held high through reset release must not read.
        req[0] = 1'b1;
        reset_n = 0; step(); step();
        reset_n = 1;
        n_strobe[0] = 0;
        repeat (8) step();
        chk("t4_held_no_read", n_strobe[0], 0);
        req[0] = 1'b0; repeat (3) step();
        req[0] = 1'b1; repeat (4) step();
        req[0] = 1'b0; repeat (6) step();
        chk("t4_rearm_one_read", n_strobe[0], 1);
        chk("t4_valid", valid[0], 1);

        // Reset one clock after a strobe abandons the read.
        req[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (strobe[0] === 1'b1) found = 1;
        end
        chk("t5_strobe_seen", found, 1);
        step();
        reset_n = 0; req[0] = 1'b0;
        step();
        chk("t5_valid_reset", valid[0], 0);
        chk("t5_data_reset", data[7:0], 8'h00);
        reset_n = 1;
        repeat (8) step();
        chk("t5_no_capture", {valid[0], data[7:0]}, 9'h000);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5) == 0) req[c] = ~req[c];
                empty[c] = ($urandom_range(3) == 0);
                clear[c] = ($urandom_range(31) == 0);
            end
            q = $urandom;
            step();
        end
        req = '0; empty = '0; clear = 4'hF;
        repeat (8) step();
        clear = '0;

`ifdef FIFO_PORT_READER_UFL_CNT_EN
        empty[1] = 1'b1;
        for (int i = 0; i < 260; i++) begin
            req[1] = 1'b1; repeat (3) step();
            req[1] = 1'b0; repeat (3) step();
        end
        repeat (4) step();
        chk("ufl_count_saturated", ucount[15:8], 8'hFF);
        clear[1] = 1'b1; step(); clear[1] = 1'b0;
        chk("ufl_count_cleared", ucount[15:8], 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
